// File: rtl/sargantana_itag_ctrl_pkg.sv
// Shared types and default geometry for the instruction-cache tag controller.
package sargantana_icache_pkg;

  localparam int ICACHE_N_WAY_DEF = 4;
  localparam int TAG_DEPTH_DEF    = 64;
  localparam int TAG_WIDHT_DEF    = 20;

  typedef enum logic [1:0] {
    IDLE,
    CMP,
    MISS_WAIT,
    WRITE
  } itag_state_e;

endpackage

// File: rtl/sargantana_itag_ctrl_if.sv
// Tag-memory request/response bus between the tag controller and the tag arrays.
interface sargantana_itag_ctrl_if #(
  parameter int ICACHE_N_WAY   = 4,
  parameter int TAG_ADDR_WIDHT = 6,
  parameter int TAG_WIDHT      = 20
);

  logic [ICACHE_N_WAY-1:0]                tmem_req_o;
  logic                                   tmem_we_o;
  logic                                   tmem_vbit_o;
  logic                                   tmem_flush_o;
  logic [TAG_WIDHT-1:0]                   tmem_data_o;
  logic [TAG_ADDR_WIDHT-1:0]              tmem_addr_o;
  logic [ICACHE_N_WAY-1:0][TAG_WIDHT-1:0] tmem_tag_i;
  logic [ICACHE_N_WAY-1:0]                tmem_vbit_i;

  modport master (
    output tmem_req_o, tmem_we_o, tmem_vbit_o, tmem_flush_o, tmem_data_o, tmem_addr_o,
    input  tmem_tag_i, tmem_vbit_i
  );

  modport slave (
    input  tmem_req_o, tmem_we_o, tmem_vbit_o, tmem_flush_o, tmem_data_o, tmem_addr_o,
    output tmem_tag_i, tmem_vbit_i
  );

endinterface

// File: rtl/sargantana_itag_ctrl_victim_sel.sv
// Miss victim choice: lowest invalid way first, otherwise a round-robin pointer
// that only advances once the way it chose has actually been written.
module sargantana_itag_victim_sel #(
  parameter int ICACHE_N_WAY = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [ICACHE_N_WAY-1:0] vbit_i,
  input  logic                    capture_i,
  input  logic                    commit_i,
  output logic [ICACHE_N_WAY-1:0] victim_o
);

  localparam int PTR_W = (ICACHE_N_WAY > 1) ? $clog2(ICACHE_N_WAY) : 1;

  logic [PTR_W-1:0]        rr_q, rr_d;
  logic                    rr_used_q, rr_used_d;
  logic [ICACHE_N_WAY-1:0] invalid_oh;
  logic [ICACHE_N_WAY-1:0] rr_oh;
  logic                    any_invalid;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    invalid_oh  = '0;
    any_invalid = 1'b0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      if (!vbit_i[w] && !any_invalid) begin
        invalid_oh[w] = 1'b1;
        any_invalid   = 1'b1;
      end
    end
    rr_oh        = '0;
    rr_oh[rr_q]  = 1'b1;
    victim_o     = any_invalid ? invalid_oh : rr_oh;
  end

  always_comb begin
    rr_used_d = capture_i ? !any_invalid : rr_used_q;
    rr_d      = rr_q;
    if (commit_i && rr_used_q) begin
      rr_d = (rr_q == PTR_W'(ICACHE_N_WAY - 1)) ? '0 : rr_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      rr_q      <= '0;
      rr_used_q <= 1'b0;
    end else begin
      rr_q      <= rr_d;
      rr_used_q <= rr_used_d;
    end
  end

endmodule

// File: rtl/sargantana_itag_ctrl.sv
// Instruction-cache tag controller: tag lookup, hit/victim reporting and
// victim tag commit once the refill data has landed.
module sargantana_itag_ctrl
  import sargantana_icache_pkg::*;
#(
  parameter int ICACHE_N_WAY   = ICACHE_N_WAY_DEF,
  parameter int TAG_DEPTH      = TAG_DEPTH_DEF,
  parameter int TAG_ADDR_WIDHT = $clog2(TAG_DEPTH),
  parameter int TAG_WIDHT      = TAG_WIDHT_DEF
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      flush_i,
  input  logic                      lookup_valid_i,
  output logic                      lookup_ready_o,
  input  logic [TAG_ADDR_WIDHT-1:0] lookup_idx_i,
  input  logic [TAG_WIDHT-1:0]      lookup_tag_i,
  output logic                      resp_valid_o,
  output logic                      resp_hit_o,
  output logic [ICACHE_N_WAY-1:0]   resp_way_o,
  input  logic                      refill_done_i,
  sargantana_itag_ctrl_if.master    tmem
);

  itag_state_e               state_q, state_d;
  logic [TAG_ADDR_WIDHT-1:0] idx_q, idx_d;
  logic [TAG_WIDHT-1:0]      tag_q, tag_d;
  logic [ICACHE_N_WAY-1:0]   victim_q, victim_d;

  logic [ICACHE_N_WAY-1:0]   hit_vec, hit_oh, victim_oh;
  logic                      hit;
  logic                      accept, in_cmp, in_write;

  // Flush and reset both mask every request and response output.
  assign lookup_ready_o = rstn_i && !flush_i && (state_q == IDLE);
  assign accept         = lookup_valid_i && lookup_ready_o;
  assign in_cmp         = rstn_i && !flush_i && (state_q == CMP);
  assign in_write       = rstn_i && !flush_i && (state_q == WRITE);

  always_comb begin
    hit_oh = '0;
    hit    = 1'b0;
    for (int w = 0; w < ICACHE_N_WAY; w++) begin
      hit_vec[w] = tmem.tmem_vbit_i[w] && (tmem.tmem_tag_i[w] == tag_q);
      if (hit_vec[w] && !hit) begin
        hit_oh[w] = 1'b1;
        hit       = 1'b1;
      end
    end
  end

  sargantana_itag_victim_sel #(
    .ICACHE_N_WAY (ICACHE_N_WAY)
  ) u_victim_sel (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .vbit_i    (tmem.tmem_vbit_i),
    .capture_i (in_cmp && !hit),
    .commit_i  (in_write),
    .victim_o  (victim_oh)
  );

  always_comb begin
    tmem.tmem_req_o   = '0;
    tmem.tmem_we_o    = 1'b0;
    tmem.tmem_vbit_o  = 1'b0;
    tmem.tmem_flush_o = rstn_i && flush_i;
    tmem.tmem_data_o  = '0;
    tmem.tmem_addr_o  = '0;
    resp_valid_o      = 1'b0;
    resp_hit_o        = 1'b0;
    resp_way_o        = '0;
    if (accept) begin
      tmem.tmem_req_o  = '1;
      tmem.tmem_addr_o = lookup_idx_i;
    end
    if (in_cmp) begin
      resp_valid_o = 1'b1;
      resp_hit_o   = hit;
      resp_way_o   = hit ? hit_oh : victim_oh;
    end
    if (in_write) begin
      tmem.tmem_req_o  = victim_q;
      tmem.tmem_we_o   = 1'b1;
      tmem.tmem_vbit_o = 1'b1;
      tmem.tmem_data_o = tag_q;
      tmem.tmem_addr_o = idx_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tag_d    = tag_q;
    victim_d = victim_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (lookup_valid_i) begin
            idx_d   = lookup_idx_i;
            tag_d   = lookup_tag_i;
            state_d = CMP;
          end
        end
        CMP: begin
          if (hit) begin
            state_d = IDLE;
          end else begin
            victim_d = victim_oh;
            state_d  = MISS_WAIT;
          end
        end
        MISS_WAIT: if (refill_done_i) state_d = WRITE;
        WRITE:     state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      tag_q    <= '0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      tag_q    <= tag_d;
      victim_q <= victim_d;
    end
  end

endmodule
